// File: rtl/cpu_classifier_ctrl.sv
// Avalon-MM controlled sequencer for a classifier datapath: start/busy control,
// timeout watchdog, sticky W1C status, captured result and level interrupt.
module cpu_classifier_ctrl #(
  parameter int          CLASS_W         = 8,
  parameter logic [15:0] TIMEOUT_DEFAULT = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               cls_start,
  input  logic               cls_done,
  input  logic [CLASS_W-1:0] cls_class,
  output logic               irq
);

  localparam logic [1:0] ADDR_CONTROL = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_RESULT  = 2'd2;
  localparam logic [1:0] ADDR_LIMIT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_t;

  state_t             state_r;
  logic [15:0]        cnt_r;
  logic [15:0]        limit_r;
  logic               cls_start_r;
  logic [CLASS_W-1:0] cls_hold_r;
  logic [CLASS_W-1:0] result_class_r;
  logic               result_valid_r;
  logic               irq_en_r;
  logic [2:0]         status_r;
  logic               irq_r;
  logic [31:0]        readdata_r;

  logic               wr_s;
  logic               ctrl_wr_s;
  logic               stat_wr_s;
  logic               lim_wr_s;
  logic               start_req_s;
  logic               busy_s;
  logic [2:0]         stat_set_s;
  logic [2:0]         stat_clr_s;
  logic [31:0]        rd_mux_s;
  logic               unused_s;

  assign wr_s        = chipselect & ~write_n;
  assign ctrl_wr_s   = wr_s & (address == ADDR_CONTROL);
  assign stat_wr_s   = wr_s & (address == ADDR_STATUS);
  assign lim_wr_s    = wr_s & (address == ADDR_LIMIT);
  assign start_req_s = ctrl_wr_s & writedata[0];
  assign busy_s      = (state_r != S_IDLE);
  assign unused_s    = ^writedata[31:16];

  // Hardware set sources and software W1C mask for STATUS
  always_comb begin
    stat_set_s    = 3'b000;
    stat_clr_s    = 3'b000;
    stat_set_s[0] = (state_r == S_CAPTURE);
    stat_set_s[1] = (state_r == S_WAIT) && !cls_done && (cnt_r == limit_r);
    stat_set_s[2] = start_req_s && busy_s;
    if (stat_wr_s) begin
      stat_clr_s = writedata[2:0];
    end else begin
      stat_clr_s = 3'b000;
    end
  end

  // Sequencer FSM with registered start pulse, wait counter and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= S_IDLE;
      cnt_r          <= 16'd0;
      cls_start_r    <= 1'b0;
      cls_hold_r     <= '0;
      result_class_r <= '0;
      result_valid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start_req_s) begin
            state_r        <= S_START;
            cnt_r          <= 16'd0;
            result_valid_r <= 1'b0;
            cls_start_r    <= 1'b1;
          end else begin
            state_r     <= S_IDLE;
            cls_start_r <= 1'b0;
          end
        end
        S_START: begin
          cls_start_r <= 1'b0;
          cnt_r       <= 16'd0;
          state_r     <= S_WAIT;
        end
        S_WAIT: begin
          cls_start_r <= 1'b0;
          // completion beats a coincident timeout
          if (cls_done) begin
            cls_hold_r <= cls_class;
            state_r    <= S_CAPTURE;
          end else if (cnt_r == limit_r) begin
            state_r <= S_IDLE;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        S_CAPTURE: begin
          cls_start_r    <= 1'b0;
          result_class_r <= cls_hold_r;
          result_valid_r <= 1'b1;
          state_r        <= S_IDLE;
        end
        default: begin
          cls_start_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  // Sticky status bits: a hardware set in the same cycle as a clear survives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      status_r <= 3'b000;
    end else begin
      status_r <= stat_set_s | (status_r & ~stat_clr_s);
    end
  end

  // Software-owned control fields
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en_r <= 1'b0;
      limit_r  <= TIMEOUT_DEFAULT;
    end else begin
      if (ctrl_wr_s) begin
        irq_en_r <= writedata[1];
      end
      if (lim_wr_s) begin
        limit_r <= writedata[15:0];
      end
    end
  end

  // Read-back multiplexer, zero-extended
  always_comb begin
    rd_mux_s = 32'd0;
    case (address)
      ADDR_CONTROL: begin
        rd_mux_s[0] = busy_s;
        rd_mux_s[1] = irq_en_r;
      end
      ADDR_STATUS: begin
        rd_mux_s[2:0] = status_r;
      end
      ADDR_RESULT: begin
        rd_mux_s[CLASS_W-1:0] = result_class_r;
        rd_mux_s[31]          = result_valid_r;
      end
      ADDR_LIMIT: begin
        rd_mux_s[15:0] = limit_r;
      end
      default: begin
        rd_mux_s = 32'd0;
      end
    endcase
  end

  // Registered read data and interrupt
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      readdata_r <= rd_mux_s;
      irq_r      <= irq_en_r & (status_r[0] | status_r[1]);
    end
  end

  assign readdata  = readdata_r;
  assign cls_start = cls_start_r;
  assign irq       = irq_r;

endmodule

// File: tb/tb_cpu_classifier_ctrl.sv
// Self-checking bench for cpu_classifier_ctrl: directed scenarios plus random
// operations predicted by a transaction-level model of start/done/timeout rules.
module tb_cpu_classifier_ctrl;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        cls_start;
  logic        cls_done;
  logic [7:0]  cls_class;
  logic        irq;

  int checks = 0;
  int errors = 0;

  cpu_classifier_ctrl #(.CLASS_W(8), .TIMEOUT_DEFAULT(16'hFFFF)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .cls_start(cls_start), .cls_done(cls_done), .cls_class(cls_class), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a;
    @(negedge clk);
    d = readdata;
  endtask

  // One classifier operation; done_at = cycles after the cls_start cycle
  // (large value means no completion). Model: completion is seen only in a
  // WAIT cycle, WAIT cycles carry counter 0..lim, so done wins iff 1<=done_at<=lim+1.
  task automatic run_op(input string tag, input int lim, input int done_at,
                        input logic [7:0] cls, input logic en);
    logic [31:0] rd;
    int found, starts, busy, win;
    bit ok;
    ok = (done_at >= 1) && (done_at <= lim + 1);
    write_reg(2'd1, 32'h7);
    write_reg(2'd3, lim);
    write_reg(2'd0, {30'd0, en, 1'b1});
    address = 2'd0;
    found = 0;
    for (int i = 0; i < 8; i++) begin
      if (cls_start) begin found = 1; break; end
      @(negedge clk);
    end
    check({tag, "_start_seen"}, found, 1);
    starts = 0; busy = 0; win = lim + 8;
    for (int k = 0; k <= win; k++) begin
      starts += int'(cls_start);
      busy   += int'(readdata[0]);
      cls_done  = (k == done_at);
      cls_class = (k == done_at) ? cls : 8'($urandom);
      @(negedge clk);
    end
    cls_done = 1'b0;
    check({tag, "_start_pulses"}, starts, 1);
    check({tag, "_busy_cycles"}, busy, ok ? done_at + 2 : lim + 2);
    read_reg(2'd1, rd);
    check({tag, "_status"}, rd, ok ? 32'h1 : 32'h2);
    read_reg(2'd2, rd);
    if (ok) check({tag, "_result"}, rd, {1'b1, 23'd0, cls});
    else    check({tag, "_result_valid"}, {31'd0, rd[31]}, 32'd0);
    read_reg(2'd0, rd);
    check({tag, "_control"}, rd, {30'd0, en, 1'b0});
    check({tag, "_irq"}, {31'd0, irq}, {31'd0, en});
  endtask

  initial begin : stim
    logic [31:0] rd;
    int starts;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 32'd0; cls_done = 1'b0; cls_class = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    reset = 1'b0;
    read_reg(2'd0, rd); check("rst_control", rd, 32'd0);
    read_reg(2'd1, rd); check("rst_status", rd, 32'd0);
    read_reg(2'd2, rd); check("rst_result", rd, 32'd0);
    read_reg(2'd3, rd); check("rst_limit", rd, 32'h0000FFFF);
    check("rst_cls_start", {31'd0, cls_start}, 32'd0);

    run_op("nominal", 100, 10, 8'h2A, 1'b1);
    run_op("timeout", 5, 1000, 8'h00, 1'b1);
    run_op("tie", 3, 4, 8'h5C, 1'b1);
    run_op("late_done", 3, 5, 8'h11, 1'b1);
    run_op("lim0_to", 0, 1000, 8'h00, 1'b1);
    run_op("lim0_done", 0, 1, 8'hC3, 1'b0);
    run_op("done_in_start", 4, 0, 8'h77, 1'b1);

    // start while busy: flagged as overflow, no second pulse
    write_reg(2'd1, 32'h7);
    write_reg(2'd3, 32'd20);
    write_reg(2'd0, 32'h3);
    repeat (3) @(negedge clk);
    write_reg(2'd0, 32'h3);
    starts = 0;
    for (int k = 0; k < 30; k++) begin
      starts += int'(cls_start);
      @(negedge clk);
    end
    check("ovf_no_restart", starts, 0);
    read_reg(2'd1, rd); check("ovf_status", rd, 32'h6);
    write_reg(2'd1, 32'h4);
    read_reg(2'd1, rd); check("ovf_w1c", rd, 32'h2);
    write_reg(2'd0, 32'h0);
    read_reg(2'd0, rd); check("irqen_off", rd, 32'h0);
    repeat (2) @(negedge clk);
    check("irq_masked", {31'd0, irq}, 32'd0);
    write_reg(2'd0, 32'h2);
    read_reg(2'd0, rd); check("irqen_on", rd, 32'h2);

    // W1C of done landing on the same edge as the hardware done set
    write_reg(2'd1, 32'h7);
    write_reg(2'd3, 32'd50);
    write_reg(2'd0, 32'h1);
    repeat (3) @(negedge clk);
    cls_done = 1'b1; cls_class = 8'h55;
    @(negedge clk);
    cls_done = 1'b0;
    address = 2'd1; writedata = 32'h1; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    read_reg(2'd1, rd); check("w1c_vs_set", rd, 32'h1);
    read_reg(2'd2, rd); check("w1c_result", rd, 32'h80000055);

    // reset in WAIT, with writes and completion attempted during and after
    write_reg(2'd3, 32'd100);
    write_reg(2'd0, 32'h3);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_readdata", readdata, 32'd0);
    check("mid_rst_cls_start", {31'd0, cls_start}, 32'd0);
    address = 2'd3; writedata = 32'h5; chipselect = 1'b1; write_n = 1'b0;
    cls_done = 1'b1; cls_class = 8'h99;
    repeat (2) @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; cls_done = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    cls_done = 1'b1;
    @(negedge clk);
    cls_done = 1'b0;
    repeat (3) @(negedge clk);
    read_reg(2'd0, rd); check("arst_control", rd, 32'd0);
    read_reg(2'd1, rd); check("arst_status", rd, 32'd0);
    read_reg(2'd2, rd); check("arst_result", rd, 32'd0);
    read_reg(2'd3, rd); check("arst_limit", rd, 32'h0000FFFF);
    check("arst_irq", {31'd0, irq}, 32'd0);

    for (int n = 0; n < 12; n++) begin
      int lim, d;
      lim = int'($urandom_range(0, 12));
      d = ($urandom_range(0, 3) == 0) ? 1000 : int'($urandom_range(0, lim + 3));
      run_op($sformatf("rand%0d", n), lim, d, 8'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
